// File: rtl/overflow_counter_if.sv
// Control and status bundle for overflow_counter.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface overflow_counter_if #(
    parameter int BITWIDTH = 8,
    parameter int EVCNT_W  = 4
);
    logic                en;
    logic                up;
    logic                load;
    logic [BITWIDTH-1:0] load_val;
    logic                clr_flag;
    logic [BITWIDTH-1:0] count;
    logic [BITWIDTH-1:0] carry_mask;
    logic                terminal;
    logic                ovf_pulse;
    logic                ovf_sticky;
    logic [EVCNT_W-1:0]  ev_count;

    // Controller side drives commands and observes status.
    modport master (
        output en, up, load, load_val, clr_flag,
        input  count, carry_mask, terminal, ovf_pulse, ovf_sticky, ev_count
    );

    // Counter side consumes commands and drives status.
    modport slave (
        input  en, up, load, load_val, clr_flag,
        output count, carry_mask, terminal, ovf_pulse, ovf_sticky, ev_count
    );
endinterface

// File: rtl/overflow_counter.sv
// Up/down counter with wrap or saturate at the boundary, event pulse, sticky flag, event tally.
// Latency: count/flags update one cycle after the command; carry_mask/terminal are combinational.
// Backpressure: none; a command (rst > load > en) is taken every cycle.
module overflow_counter #(
    parameter int BITWIDTH = 8,
    parameter int SATURATE = 0,
    parameter int EVCNT_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    overflow_counter_if.slave bus
);
    localparam logic [BITWIDTH-1:0] ONE    = {{(BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVCNT_W-1:0]  EV_ONE = {{(EVCNT_W-1){1'b0}}, 1'b1};
    localparam logic [EVCNT_W-1:0]  EV_MAX = {EVCNT_W{1'b1}};

    logic [BITWIDTH-1:0] r_count;
    logic                r_pulse;
    logic                r_sticky;
    logic [EVCNT_W-1:0]  r_ev;

    logic [BITWIDTH-1:0] w_mask;
    logic                w_term;
    logic                w_event;

    // Carry-propagate chain: bit k is set when every lower bit would ripple in the current direction.
    always_comb begin
        w_mask    = '0;
        w_mask[0] = 1'b1;
        for (int k = 1; k < BITWIDTH; k++) begin
            w_mask[k] = w_mask[k-1] & (bus.up ? r_count[k-1] : ~r_count[k-1]);
        end
    end

    assign w_term  = w_mask[BITWIDTH-1] &
                     (bus.up ? r_count[BITWIDTH-1] : ~r_count[BITWIDTH-1]);
    // A load always wins over counting, so it can never be an overflow.
    assign w_event = bus.en & ~bus.load & w_term;

    // Counter register: reset, then load, then step; saturate mode freezes at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (bus.load) begin
            r_count <= bus.load_val;
        end else if (bus.en) begin
            if (w_event && (SATURATE != 0)) begin
                r_count <= r_count;
            end else if (bus.up) begin
                r_count <= r_count + ONE;
            end else begin
                r_count <= r_count - ONE;
            end
        end
    end

    // Event status: a coincident clear loses to a new event, so the tally restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse  <= 1'b0;
            r_sticky <= 1'b0;
            r_ev     <= '0;
        end else begin
            r_pulse <= w_event;
            if (w_event) begin
                r_sticky <= 1'b1;
                if (bus.clr_flag) begin
                    r_ev <= EV_ONE;
                end else if (r_ev != EV_MAX) begin
                    r_ev <= r_ev + EV_ONE;
                end
            end else if (bus.clr_flag) begin
                r_sticky <= 1'b0;
                r_ev     <= '0;
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.carry_mask = w_mask;
    assign bus.terminal   = w_term;
    assign bus.ovf_pulse  = r_pulse;
    assign bus.ovf_sticky = r_sticky;
    assign bus.ev_count   = r_ev;
endmodule

// File: tb/tb_overflow_counter.sv
// Scoreboard bench for overflow_counter: one wrap-mode and one saturate-mode instance.
// Stimulus drives on the falling edge and queues the expected post-edge state.
// A monitor samples shortly after each rising edge and retires matching entries.
module tb_overflow_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    overflow_counter_if #(.BITWIDTH(8), .EVCNT_W(4)) wif ();
    overflow_counter_if #(.BITWIDTH(8), .EVCNT_W(4)) sif ();

    overflow_counter #(.BITWIDTH(8), .SATURATE(0), .EVCNT_W(4)) u_wrap (
        .clk (clk), .rst (rst), .bus (wif.slave)
    );
    overflow_counter #(.BITWIDTH(8), .SATURATE(1), .EVCNT_W(4)) u_sat (
        .clk (clk), .rst (rst), .bus (sif.slave)
    );

    typedef struct {
        int         cyc;
        bit         sel;
        logic [7:0] cnt;
        logic       p;
        logic       s;
        logic [3:0] ev;
        bit         chk;
        logic [7:0] mask;
        logic       term;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    task automatic drive(input bit sel, input logic r, input logic en, input logic up,
                         input logic ld, input logic [7:0] lv, input logic clr);
        @(negedge clk);
        rst = r;
        wif.up = up;
        sif.up = up;
        wif.load_val = lv;
        sif.load_val = lv;
        wif.en   = sel ? 1'b0 : en;
        wif.load = sel ? 1'b0 : ld;
        wif.clr_flag = sel ? 1'b0 : clr;
        sif.en   = sel ? en  : 1'b0;
        sif.load = sel ? ld  : 1'b0;
        sif.clr_flag = sel ? clr : 1'b0;
    endtask

    task automatic expect_st(input string name, input bit sel, input logic [7:0] ecnt,
                             input logic ep, input logic es, input logic [3:0] eev,
                             input bit chk, input logic [7:0] emask, input logic eterm);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = sel;
        e.cnt = ecnt;
        e.p = ep;
        e.s = es;
        e.ev = eev;
        e.chk = chk;
        e.mask = emask;
        e.term = eterm;
        sb.push_back(e);
        tq.push_back(name);
    endtask

    task automatic step(input string name, input bit sel, input logic r, input logic en,
                        input logic up, input logic ld, input logic [7:0] lv, input logic clr,
                        input logic [7:0] ecnt, input logic ep, input logic es,
                        input logic [3:0] eev, input bit chk = 1'b0,
                        input logic [7:0] emask = 8'h00, input logic eterm = 1'b0);
        drive(sel, r, en, up, ld, lv, clr);
        expect_st(name, sel, ecnt, ep, es, eev, chk, emask, eterm);
    endtask

    // Monitor: compare every entry due at this cycle against the selected instance.
    initial begin
        exp_t       e;
        string      nm;
        logic [7:0] a_cnt, a_mask;
        logic       a_p, a_s, a_term;
        logic [3:0] a_ev;
        bit         ok;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e  = sb.pop_front();
                nm = tq.pop_front();
                if (e.sel) begin
                    a_cnt = sif.count; a_p = sif.ovf_pulse; a_s = sif.ovf_sticky;
                    a_ev = sif.ev_count; a_mask = sif.carry_mask; a_term = sif.terminal;
                end else begin
                    a_cnt = wif.count; a_p = wif.ovf_pulse; a_s = wif.ovf_sticky;
                    a_ev = wif.ev_count; a_mask = wif.carry_mask; a_term = wif.terminal;
                end
                ok = (e.cyc == cyc) && (a_cnt === e.cnt) && (a_p === e.p) &&
                     (a_s === e.s) && (a_ev === e.ev);
                if (e.chk) ok = ok && (a_mask === e.mask) && (a_term === e.term);
                n_checks++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d(due %0d): got cnt=%h p=%b s=%b ev=%0d mask=%h t=%b, want cnt=%h p=%b s=%b ev=%0d mask=%h t=%b (mask/t checked=%0b)",
                             nm, cyc, e.cyc, a_cnt, a_p, a_s, a_ev, a_mask, a_term,
                             e.cnt, e.p, e.s, e.ev, e.mask, e.term, e.chk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1);
    end

    initial begin
        wif.en = 0; wif.up = 1; wif.load = 0; wif.load_val = 0; wif.clr_flag = 0;
        sif.en = 0; sif.up = 1; sif.load = 0; sif.load_val = 0; sif.clr_flag = 0;

        // Reset state, both directions of the combinational mask.
        drive(0, 1, 0, 1, 0, 8'h00, 0);
        expect_st("rst_up_wrap", 0, 8'h00, 0, 0, 4'd0, 1, 8'h01, 0);
        expect_st("rst_up_sat",  1, 8'h00, 0, 0, 4'd0, 1, 8'h01, 0);
        drive(0, 1, 0, 0, 0, 8'h00, 0);
        expect_st("rst_dn_wrap", 0, 8'h00, 0, 0, 4'd0, 1, 8'hFF, 1);
        expect_st("rst_dn_sat",  1, 8'h00, 0, 0, 4'd0, 1, 8'hFF, 1);

        // Wrap mode: count through all-ones.
        step("w_load_fd", 0, 0, 0, 1, 1, 8'hFD, 0, 8'hFD, 0, 0, 4'd0);
        step("w_up_fe",   0, 0, 1, 1, 0, 8'h00, 0, 8'hFE, 0, 0, 4'd0);
        step("w_up_ff",   0, 0, 1, 1, 0, 8'h00, 0, 8'hFF, 0, 0, 4'd0, 1, 8'hFF, 1);
        step("w_wrap_00", 0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1, 4'd1);
        step("w_up_01",   0, 0, 1, 1, 0, 8'h00, 0, 8'h01, 0, 1, 4'd1);

        // Carry mask patterns.
        step("mask_07_up", 0, 0, 0, 1, 1, 8'h07, 0, 8'h07, 0, 1, 4'd1, 1, 8'h0F, 0);
        step("mask_f8_dn", 0, 0, 0, 0, 1, 8'hF8, 0, 8'hF8, 0, 1, 4'd1, 1, 8'h0F, 0);
        step("mask_ff_up", 0, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 1, 4'd1, 1, 8'hFF, 1);

        // Priority: load beats an event; reset beats load and event.
        step("prio_load",   0, 0, 1, 1, 1, 8'h10, 0, 8'h10, 0, 1, 4'd1);
        step("reload_ff",   0, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 1, 4'd1);
        step("prio_rst",    0, 1, 1, 1, 1, 8'h10, 0, 8'h00, 0, 0, 4'd0, 1, 8'h01, 0);
        step("reload_ff2",  0, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 0, 4'd0);
        step("rst_on_evt",  0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 4'd0);

        // Hold, then flag clear.
        step("h_load_ff", 0, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 0, 4'd0);
        step("h_wrap",    0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1, 4'd1);
        step("h_load_42", 0, 0, 0, 1, 1, 8'h42, 0, 8'h42, 0, 1, 4'd1);
        for (int i = 0; i < 5; i++)
            step("hold_42", 0, 0, 0, 1, 0, 8'h00, 0, 8'h42, 0, 1, 4'd1);
        step("clr_only",  0, 0, 0, 1, 0, 8'h00, 1, 8'h42, 0, 0, 4'd0);

        // Wrap mode underflow.
        step("d_load_00", 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 4'd0);
        step("d_wrap_ff", 0, 0, 1, 0, 0, 8'h00, 0, 8'hFF, 1, 1, 4'd1);
        step("d_dn_fe",   0, 0, 1, 0, 0, 8'h00, 0, 8'hFE, 0, 1, 4'd1);

        // Saturate mode at zero.
        step("s_load_01", 1, 0, 0, 0, 1, 8'h01, 0, 8'h01, 0, 0, 4'd0);
        step("s_dn_00",   1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 4'd0);
        step("s_sat_1",   1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 4'd1);
        step("s_sat_2",   1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 4'd2);
        step("s_sat_3",   1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 4'd3);
        step("s_idle",    1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 4'd3);

        // Saturate at all-ones; event tally saturates at 15.
        step("s_load_ff", 1, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 0, 1, 4'd3);
        for (int i = 1; i <= 20; i++)
            step("s_evsat", 1, 0, 1, 1, 0, 8'h00, 0, 8'hFF, 1, 1,
                 4'((3 + i > 15) ? 15 : 3 + i));
        step("s_clr_evt", 1, 0, 1, 1, 0, 8'h00, 1, 8'hFF, 1, 1, 4'd1, 1, 8'hFF, 1);
        step("s_clr",     1, 0, 0, 1, 0, 8'h00, 1, 8'hFF, 0, 0, 4'd0);
        step("s_rst_evt", 1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 4'd0);

        drive(0, 0, 0, 1, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/overflow_counter.md
OVERFLOW_COUNTER -- requirements
Module: overflow_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled only on the rising edge of clk.
REQ-002 Parameter BITWIDTH, default 8, SHALL set the counter width (minimum 2).
REQ-003 Parameter SATURATE, default 0, SHALL select the mode: 0 = wrap-around, 1 = saturate at the boundary.
REQ-004 Parameter EVCNT_W, default 4, SHALL set the width of the overflow-event counter.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  count enable; advances the count by one step per cycle.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous parallel load of load_val.
REQ-010 load_val  input  BITWIDTH  value written to the count on load.
REQ-011 clr_flag  input  1  clears ovf_sticky and ev_count.
REQ-012 count  output  BITWIDTH  registered counter value.
REQ-013 carry_mask  output  BITWIDTH  combinational carry-propagate mask of count for the current direction.
REQ-014 terminal  output  1  combinational; count is at the boundary for the current direction.
REQ-015 ovf_pulse  output  1  registered one-cycle pulse per overflow or underflow event.
REQ-016 ovf_sticky  output  1  registered sticky event flag.
REQ-017 ev_count  output  EVCNT_W  registered count of events, saturating.

Function
REQ-018 Priority at each rising edge SHALL be rst, then load, then en; when none is active, count holds.
REQ-019 On load, count SHALL equal load_val on the next cycle, regardless of en; a load SHALL never produce an event.
REQ-020 With en=1, load=0 and no event, count SHALL become count+1 (up=1) or count-1 (up=0) on the next cycle.
REQ-021 An event SHALL occur on a cycle with en=1, load=0, rst=0, and either (up=1 and count = all ones) or (up=0 and count = 0).
REQ-022 On an event with SATURATE=0, count SHALL wrap: all ones goes to 0, and 0 goes to all ones.
REQ-023 On an event with SATURATE=1, count SHALL hold its boundary value.
REQ-024 carry_mask bit 0 SHALL be 1.
REQ-025 For k>=1, carry_mask bit k SHALL be the AND of count bits 0..k-1 when up=1, and the AND of the inverted count bits 0..k-1 when up=0.
REQ-026 terminal SHALL equal carry_mask[BITWIDTH-1] AND count[BITWIDTH-1] when up=1, and carry_mask[BITWIDTH-1] AND NOT count[BITWIDTH-1] when up=0.
REQ-027 ovf_pulse SHALL be 1 in the cycle immediately after each event and 0 otherwise; back-to-back events in wrap mode with BITWIDTH>=2 cannot occur.
REQ-028 In saturate mode with en held at the boundary, an event SHALL occur every cycle, and ovf_pulse SHALL stay high on consecutive cycles.
REQ-029 ovf_sticky SHALL set on the cycle after an event and SHALL clear only on rst or clr_flag.
REQ-030 ev_count SHALL increment by 1 per event and SHALL saturate at 2^EVCNT_W-1 with no wrap.
REQ-031 If clr_flag and an event coincide, the set SHALL win: ovf_sticky=1 and ev_count=1 on the next cycle.
REQ-032 A direction change SHALL take effect on the same cycle: carry_mask and terminal follow up combinationally.

Reset
REQ-033 While rst=1 at an edge, the next cycle SHALL have count=0, ovf_pulse=0, ovf_sticky=0 and ev_count=0.
REQ-034 carry_mask and terminal SHALL follow from count=0: for up=1, mask=0...01 and terminal=0; for up=0, mask=all ones and terminal=1.
REQ-035 rst asserted mid-count or coincident with an event SHALL discard the event: no pulse, no flag, no ev_count increment.

Verification (BITWIDTH=8, EVCNT_W=4)
REQ-036 SATURATE=0: load 0xFD, then en=1, up=1 for 4 cycles -> count is FE, FF, 00, 01; ovf_pulse is high only in the cycle in which count=00; ovf_sticky=1; ev_count=1.
REQ-037 SATURATE=1: load 0x01, then en=1, up=0 for 4 cycles -> count is 00, 00, 00, 00; ovf_pulse is high for the 3 cycles after count first reads 00; ev_count=3.
REQ-038 carry_mask check: count=0x07, up=1 -> carry_mask=0x0F, terminal=0; count=0xF8, up=0 -> carry_mask=0x0F, terminal=0; count=0xFF, up=1 -> terminal=1.
REQ-039 Saturating event counter: SATURATE=1, count=0xFF, en=1, up=1 for 20 cycles -> ev_count reaches 15 and holds; clr_flag coincident with an event -> next cycle ev_count=1, ovf_sticky=1.
REQ-040 Priority: count=0xFF, en=1, up=1, load=1, load_val=0x10 -> count=0x10 and no event; rst=1 in the same cycle -> count=0x00 and all flags 0.
REQ-041 Hold: en=0 for 5 cycles at count=0x42 -> count stays 0x42 and ovf_pulse stays 0; clr_flag alone clears ovf_sticky on the next cycle.
